// File: rtl/mips_debug_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_debug_unit                                                          |
// | UART-command debug controller for the MIPS pipeline. Handles run, step   |
// | and the PC / cycle / register / memory dump stream.                      |
// | Optional macro MIPS_DEBUG_UNIT_CHECKSUM_EN appends an XOR checksum byte. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_debug_unit #(
  parameter int NB_BITS     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_ADDR     = 10,
  parameter int N_MEM_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_debug,
  output logic               o_step,
  output logic [NB_REG-1:0]  o_reg_sel,
  input  logic [NB_BITS-1:0] i_reg_data,
  output logic [NB_ADDR-1:0] o_mem_addr,
  input  logic [NB_BITS-1:0] i_mem_data,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic               i_halt
);

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;

  localparam int N_REGS         = 1 << NB_REG;
  localparam int BYTES_PER_WORD = NB_BITS / 8;
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int REG_BASE       = 2;
  localparam int MEM_BASE       = REG_BASE + N_REGS;
  localparam int LAST_WORD      = MEM_BASE + N_MEM_WORDS - 1;
`ifdef MIPS_DEBUG_UNIT_CHECKSUM_EN
  localparam int FINAL_WORD     = LAST_WORD + 1;
`else
  localparam int FINAL_WORD     = LAST_WORD;
`endif
  localparam int IDX_W          = $clog2(FINAL_WORD + 1);

  localparam logic [IDX_W-1:0] IDX_PC    = '0;
  localparam logic [IDX_W-1:0] IDX_CNT   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_REG0  = IDX_W'(REG_BASE);
  localparam logic [IDX_W-1:0] IDX_MEM0  = IDX_W'(MEM_BASE);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LAST_WORD);
  localparam logic [IDX_W-1:0] IDX_FINAL = IDX_W'(FINAL_WORD);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_DUMP, S_LOAD, S_SETTLE, S_SEND, S_WAIT
  } state_t;

  state_t              state, state_next;
  logic                halted;
  logic [31:0]         cycle_cnt;
  logic [NB_BITS-1:0]  pc_snap;
  logic [IDX_W-1:0]    word_idx;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [NB_BITS-1:0]  shift;
  logic [7:0]          csum;
  logic [NB_REG-1:0]   reg_sel;
  logic [NB_ADDR-1:0]  mem_addr;
  logic                last_byte;
  logic [NB_BITS-1:0]  fetch_word;
  logic                cmd_ok;

  assign cmd_ok = i_rx_valid && ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP));

`ifdef MIPS_DEBUG_UNIT_CHECKSUM_EN
  // The checksum word carries a single byte.
  assign last_byte = (byte_cnt == BCNT_LAST) || (word_idx == IDX_FINAL);
`else
  assign last_byte = (byte_cnt == BCNT_LAST);
`endif

  always_comb begin
    fetch_word = i_mem_data;
    if (word_idx == IDX_PC)
      fetch_word = pc_snap;
    else if (word_idx == IDX_CNT)
      fetch_word = NB_BITS'(cycle_cnt);
    else if (word_idx < IDX_MEM0)
      fetch_word = i_reg_data;
  end

  always_comb begin
    state_next = state;
    o_debug    = 1'b1;
    o_step     = 1'b0;
    o_tx_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_ok) begin
          if (halted)
            state_next = S_DUMP;
          else if (i_rx_data == CMD_RUN)
            state_next = S_RUN;
          else
            state_next = S_STEP;
        end
      end
      S_RUN: begin
        o_debug = 1'b0;
        if (i_halt) state_next = S_DUMP;
      end
      S_STEP: begin
        o_step     = 1'b1;
        state_next = S_DUMP;
      end
      S_DUMP: state_next = S_LOAD;
      S_LOAD: begin
`ifdef MIPS_DEBUG_UNIT_CHECKSUM_EN
        state_next = (word_idx == IDX_FINAL) ? S_SEND : S_SETTLE;
`else
        state_next = S_SETTLE;
`endif
      end
      S_SETTLE: state_next = S_SEND;
      S_SEND: begin
        o_tx_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte)
            state_next = S_SEND;
          else if (word_idx == IDX_FINAL)
            state_next = S_IDLE;
          else
            state_next = S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      pc_snap   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      csum      <= '0;
      reg_sel   <= '0;
      mem_addr  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_RUN, S_STEP: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (i_halt) halted <= 1'b1;
        end
        S_DUMP: begin
          pc_snap  <= i_pc;
          word_idx <= '0;
          byte_cnt <= '0;
          csum     <= '0;
        end
        S_LOAD: begin
          byte_cnt <= '0;
`ifdef MIPS_DEBUG_UNIT_CHECKSUM_EN
          if (word_idx == IDX_FINAL) shift <= {csum, {(NB_BITS-8){1'b0}}};
`endif
          if (word_idx >= IDX_REG0 && word_idx < IDX_MEM0)
            reg_sel <= NB_REG'(word_idx - IDX_REG0);
          else if (word_idx >= IDX_MEM0 && word_idx <= IDX_LAST)
            mem_addr <= NB_ADDR'(word_idx - IDX_MEM0);
        end
        // Select has had a full cycle to settle through the read ports.
        S_SETTLE: shift <= fetch_word;
        S_SEND:   csum  <= csum ^ shift[NB_BITS-1 -: 8];
        S_WAIT: begin
          if (i_tx_done) begin
            shift    <= {shift[NB_BITS-9:0], 8'h00};
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (last_byte) begin
              word_idx <= word_idx + IDX_W'(1);
              if (word_idx == IDX_FINAL) begin
                reg_sel  <= '0;
                mem_addr <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data  = shift[NB_BITS-1 -: 8];
  assign o_reg_sel  = reg_sel;
  assign o_mem_addr = mem_addr;

endmodule
`default_nettype wire
